// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: binary-searches 0..2^W-1 through an external g/e/l comparator.
// Optional macro SAR_SETTLE_EN inserts one SETTLE cycle after every probe update (registered comparator).
module sar_search_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         g,
  input  logic         e,
  input  logic         l,
  output logic [W-1:0] probe,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         found,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_COMP, S_SETTLE, S_DONE} state_t;

`ifdef SAR_SETTLE_EN
  localparam state_t S_PROBE = S_SETTLE;
`else
  localparam state_t S_PROBE = S_COMP;
`endif

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] ALL_ONE = '1;

  state_t         state_q, state_d;
  logic [W-1:0]   probe_q, probe_d;
  logic [W-1:0]   lo_q, lo_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   result_q, result_d;
  logic           found_q, found_d;
  logic           err_q, err_d;
  logic [1:0]     ncode;
  logic [W-1:0]   p_inc, p_dec;

  // Midpoint with a W+1-bit sum so lo+hi cannot overflow.
  function automatic logic [W-1:0] mid_of(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[W:1];
  endfunction

  assign ncode = {1'b0, g} + {1'b0, e} + {1'b0, l};
  assign p_inc = probe_q + ONE;
  assign p_dec = probe_q - ONE;

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d    = '0;
          hi_d    = ALL_ONE;
          probe_d = ALL_ONE >> 1;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_PROBE;
        end
      end
      S_COMP: begin
        // Exhausted-range checks precede the step so probe+-1 never wraps.
        if (ncode != 2'd1) begin
          result_d = probe_q;
          err_d    = 1'b1;
          found_d  = 1'b0;
          state_d  = S_DONE;
        end else if (e) begin
          result_d = probe_q;
          found_d  = 1'b1;
          state_d  = S_DONE;
        end else if (g) begin
          if (probe_q == hi_q) begin
            result_d = probe_q;
            found_d  = 1'b0;
            state_d  = S_DONE;
          end else begin
            lo_d    = p_inc;
            probe_d = mid_of(p_inc, hi_q);
            state_d = S_PROBE;
          end
        end else begin
          if (probe_q == lo_q) begin
            result_d = probe_q;
            found_d  = 1'b0;
            state_d  = S_DONE;
          end else begin
            hi_d    = p_dec;
            probe_d = mid_of(lo_q, p_dec);
            state_d = S_PROBE;
          end
        end
      end
`ifdef SAR_SETTLE_EN
      S_SETTLE: state_d = S_COMP;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      probe_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = (state_q == S_COMP) || (state_q == S_SETTLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign found  = found_q;
  assign err    = err_q;

endmodule
